// File: rtl/kyo_sprite_pkg.sv
// Shared types and helpers for the kyo sprite address generator.
//   coord_t    : 10-bit VGA scan / sprite coordinate
//   rom_addr_t : 16-bit sprite ROM address
//   frame_size : pixels per animation frame, used for elaboration checks and frame stepping
package kyo_sprite_pkg;

  typedef logic [9:0]  coord_t;
  typedef logic [15:0] rom_addr_t;

  localparam int unsigned ROM_DEPTH   = 65536;
  localparam int unsigned FRAME_IDX_W = 3;
  localparam int unsigned MAX_FRAMES  = 1 << FRAME_IDX_W;

  function automatic int unsigned frame_size(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/kyo_sprite_addr_gen_if.sv
// Scan/sprite bus between the video timing + game logic side (master) and the
// sprite address generator (slave).
//   vs, drawX, drawY           : VGA vsync (active-low) and scan position
//   pos_x, pos_y, facing_left  : live sprite placement from game logic
//   anim_en, anim_restart      : animation control
//   rom_address, sprite_hit,
//   sprite_hit_px, frame_idx   : generator results toward the pixel stage
interface kyo_sprite_addr_gen_if;
  import kyo_sprite_pkg::*;

  logic                   vs;
  coord_t                 drawX;
  coord_t                 drawY;
  coord_t                 pos_x;
  coord_t                 pos_y;
  logic                   facing_left;
  logic                   anim_en;
  logic                   anim_restart;
  rom_addr_t              rom_address;
  logic                   sprite_hit;
  logic                   sprite_hit_px;
  logic [FRAME_IDX_W-1:0] frame_idx;

  modport master (
    output vs, drawX, drawY, pos_x, pos_y, facing_left, anim_en, anim_restart,
    input  rom_address, sprite_hit, sprite_hit_px, frame_idx
  );

  modport slave (
    input  vs, drawX, drawY, pos_x, pos_y, facing_left, anim_en, anim_restart,
    output rom_address, sprite_hit, sprite_hit_px, frame_idx
  );

endinterface

// File: rtl/kyo_anim_seq.sv
// Animation sequencer: detects the vsync falling edge, divides vsyncs down to
// animation frames and keeps the ROM base of the current frame as an accumulator.
//   vga_clk, reset_ah : pixel clock, async active-high reset
//   vs                : VGA vsync, active-low
//   anim_en           : advance animation
//   anim_restart      : force frame 0 at the next latch (highest priority)
//   frame_latch_c     : one-cycle pulse, high in the cycle the frame state updates
//   frame_idx         : current animation frame
//   frame_base        : ROM address of pixel (0,0) of the current frame
module kyo_anim_seq
  import kyo_sprite_pkg::*;
#(
  parameter int unsigned SPR_W      = 48,
  parameter int unsigned SPR_H      = 96,
  parameter int unsigned NUM_FRAMES = 6,
  parameter int unsigned FRAME_DIV  = 6
) (
  input  logic                   vga_clk,
  input  logic                   reset_ah,
  input  logic                   vs,
  input  logic                   anim_en,
  input  logic                   anim_restart,
  output logic                   frame_latch_c,
  output logic [FRAME_IDX_W-1:0] frame_idx,
  output rom_addr_t              frame_base
);

  localparam int unsigned            DIV_W      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0]       DIV_LAST   = DIV_W'(FRAME_DIV - 1);
  localparam logic [FRAME_IDX_W-1:0] IDX_LAST   = FRAME_IDX_W'(NUM_FRAMES - 1);
  localparam rom_addr_t              FRAME_STEP = 16'(frame_size(SPR_W, SPR_H));

  logic             vs_q;
  logic [DIV_W-1:0] div_q;

  // vs history resets high so a low vs straight out of reset is not mistaken for history
  assign frame_latch_c = vs_q & ~vs;

  // Divider and frame accumulator; only touched on a frame latch
  always_ff @(posedge vga_clk or posedge reset_ah) begin
    if (reset_ah) begin
      vs_q       <= 1'b1;
      div_q      <= '0;
      frame_idx  <= '0;
      frame_base <= '0;
    end else begin
      vs_q <= vs;
      if (frame_latch_c) begin
        if (anim_restart) begin
          div_q      <= '0;
          frame_idx  <= '0;
          frame_base <= '0;
        end else if (anim_en) begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (frame_idx == IDX_LAST) begin
              frame_idx  <= '0;
              frame_base <= '0;
            end else begin
              frame_idx  <= frame_idx + FRAME_IDX_W'(1);
              frame_base <= frame_base + FRAME_STEP;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/kyo_sprite_addr_gen.sv
// Sprite address generator: maps the VGA scan position to a sprite ROM address
// and in-sprite flag, with per-frame sampled position/facing and looping animation.
//   vga_clk  : pixel clock, all logic on posedge
//   reset_ah : asynchronous active-high reset
//   bus      : scan inputs, sprite controls and registered results (slave side)
module kyo_sprite_addr_gen
  import kyo_sprite_pkg::*;
#(
  parameter int unsigned SPR_W      = 48,
  parameter int unsigned SPR_H      = 96,
  parameter int unsigned NUM_FRAMES = 6,
  parameter int unsigned FRAME_DIV  = 6
) (
  input  logic                  vga_clk,
  input  logic                  reset_ah,
  kyo_sprite_addr_gen_if.slave  bus
);

  if (NUM_FRAMES * frame_size(SPR_W, SPR_H) > ROM_DEPTH) begin : g_rom_too_small
    $error("kyo_sprite_addr_gen: NUM_FRAMES*SPR_W*SPR_H exceeds 65536");
  end
  if (NUM_FRAMES < 1 || NUM_FRAMES > MAX_FRAMES) begin : g_bad_frames
    $error("kyo_sprite_addr_gen: NUM_FRAMES must be 1..8");
  end
  if (FRAME_DIV < 1) begin : g_bad_div
    $error("kyo_sprite_addr_gen: FRAME_DIV must be >= 1");
  end

  logic      frame_latch_c;
  rom_addr_t frame_base;

  kyo_anim_seq #(
    .SPR_W      (SPR_W),
    .SPR_H      (SPR_H),
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_DIV  (FRAME_DIV)
  ) u_anim_seq (
    .vga_clk       (vga_clk),
    .reset_ah      (reset_ah),
    .vs            (bus.vs),
    .anim_en       (bus.anim_en),
    .anim_restart  (bus.anim_restart),
    .frame_latch_c (frame_latch_c),
    .frame_idx     (bus.frame_idx),
    .frame_base    (frame_base)
  );

  coord_t lx;
  coord_t ly;
  logic   lface;

  // Position/facing sampled once per frame so the sprite never tears mid-scan
  always_ff @(posedge vga_clk or posedge reset_ah) begin
    if (reset_ah) begin
      lx    <= '0;
      ly    <= '0;
      lface <= 1'b0;
    end else if (frame_latch_c) begin
      lx    <= bus.pos_x;
      ly    <= bus.pos_y;
      lface <= bus.facing_left;
    end
  end

  logic [10:0] dx_c;
  logic [10:0] dy_c;
  logic [10:0] x_end_c;
  logic [10:0] y_end_c;
  logic [10:0] col_c;
  logic        hit_c;
  rom_addr_t   addr_c;

  // Hit test and address; 11-bit end points so sprites near 1023 clip instead of wrapping
  always_comb begin
    dx_c    = {1'b0, bus.drawX} - {1'b0, lx};
    dy_c    = {1'b0, bus.drawY} - {1'b0, ly};
    x_end_c = {1'b0, lx} + 11'(SPR_W);
    y_end_c = {1'b0, ly} + 11'(SPR_H);
    hit_c   = (bus.drawX >= lx) && ({1'b0, bus.drawX} < x_end_c) &&
              (bus.drawY >= ly) && ({1'b0, bus.drawY} < y_end_c);
    col_c   = lface ? (11'(SPR_W - 1) - dx_c) : dx_c;
    addr_c  = '0;
    if (hit_c) begin
      addr_c = frame_base + (16'(dy_c) * 16'(SPR_W)) + 16'(col_c);
    end
  end

  // Output registers; sprite_hit_px trails sprite_hit to line up with downstream RGB
  always_ff @(posedge vga_clk or posedge reset_ah) begin
    if (reset_ah) begin
      bus.rom_address   <= '0;
      bus.sprite_hit    <= 1'b0;
      bus.sprite_hit_px <= 1'b0;
    end else begin
      bus.rom_address   <= addr_c;
      bus.sprite_hit    <= hit_c;
      bus.sprite_hit_px <= bus.sprite_hit;
    end
  end

endmodule

// File: tb/tb_kyo_sprite_addr_gen.sv
// Scoreboard bench for kyo_sprite_addr_gen: directed scenarios followed by random
// frames, expectations from a behavioural model of the sprite/animation rules.
module tb_kyo_sprite_addr_gen;

  localparam int SPR_W      = 48;
  localparam int SPR_H      = 96;
  localparam int NUM_FRAMES = 6;
  localparam int FRAME_DIV  = 6;

  typedef struct {
    logic [15:0] addr;
    logic        hit;
    logic        hit_px;
    logic [2:0]  fidx;
  } exp_t;

  logic vga_clk;
  logic reset_ah;

  kyo_sprite_addr_gen_if bus ();

  kyo_sprite_addr_gen #(
    .SPR_W      (SPR_W),
    .SPR_H      (SPR_H),
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_DIV  (FRAME_DIV)
  ) dut (
    .vga_clk  (vga_clk),
    .reset_ah (reset_ah),
    .bus      (bus)
  );

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "init";
  exp_t  sb_q[$];

  // Reference model state
  int m_lx, m_ly, m_face, m_vsq, m_div, m_fidx, m_hitq;

  task automatic model_reset();
    m_lx = 0; m_ly = 0; m_face = 0; m_vsq = 1; m_div = 0; m_fidx = 0; m_hitq = 0;
  endtask

  // Predict the result of the coming posedge from the current inputs, then advance one cycle
  task automatic tick();
    exp_t e;
    int   x, y, dx, dy, col, a;
    bit   hit;
    x   = int'(bus.drawX);
    y   = int'(bus.drawY);
    hit = (x >= m_lx) && (x < m_lx + SPR_W) && (y >= m_ly) && (y < m_ly + SPR_H);
    a   = 0;
    if (hit) begin
      dx  = x - m_lx;
      dy  = y - m_ly;
      col = (m_face != 0) ? (SPR_W - 1 - dx) : dx;
      a   = (m_fidx * SPR_W * SPR_H + dy * SPR_W + col) % 65536;
    end
    if (m_vsq == 1 && bus.vs == 1'b0) begin
      m_lx   = int'(bus.pos_x);
      m_ly   = int'(bus.pos_y);
      m_face = int'(bus.facing_left);
      if (bus.anim_restart) begin
        m_fidx = 0;
        m_div  = 0;
      end else if (bus.anim_en) begin
        m_div = m_div + 1;
        if (m_div == FRAME_DIV) begin
          m_div  = 0;
          m_fidx = (m_fidx + 1) % NUM_FRAMES;
        end
      end
    end
    e.addr   = 16'(a);
    e.hit    = hit;
    e.hit_px = (m_hitq != 0);
    e.fidx   = 3'(m_fidx);
    m_hitq   = int'(hit);
    m_vsq    = int'(bus.vs);
    sb_q.push_back(e);
    @(negedge vga_clk);
  endtask

  task automatic pixel(input int x, input int y);
    if (x < 0) x = 0;
    if (x > 1023) x = 1023;
    if (y < 0) y = 0;
    if (y > 1023) y = 1023;
    bus.drawX = 10'(x);
    bus.drawY = 10'(y);
    tick();
  endtask

  task automatic set_sprite(input int px, input int py, input bit face, input bit en, input bit rs);
    bus.pos_x        = 10'(px);
    bus.pos_y        = 10'(py);
    bus.facing_left  = face;
    bus.anim_en      = en;
    bus.anim_restart = rs;
  endtask

  // One vsync pulse, scanning off in the blanking corner
  task automatic vsync();
    bus.vs    = 1'b0;
    bus.drawX = 10'd1023;
    bus.drawY = 10'd1023;
    tick();
    tick();
    bus.vs = 1'b1;
    tick();
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if (bus.rom_address !== 16'd0 || bus.sprite_hit !== 1'b0 ||
        bus.sprite_hit_px !== 1'b0 || bus.frame_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL %s: got addr=%0d hit=%b px=%b fidx=%0d, want all zero",
               name, bus.rom_address, bus.sprite_hit, bus.sprite_hit_px, bus.frame_idx);
    end
  endtask

  // Monitor: compare every registered output against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(posedge vga_clk);
      #2;
      if (!reset_ah && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (bus.rom_address !== e.addr || bus.sprite_hit !== e.hit ||
            bus.sprite_hit_px !== e.hit_px || bus.frame_idx !== e.fidx) begin
          n_fail++;
          $display("FAIL %s @%0t: got addr=%0d hit=%b px=%b fidx=%0d, want addr=%0d hit=%b px=%b fidx=%0d",
                   phase, $time, bus.rom_address, bus.sprite_hit, bus.sprite_hit_px,
                   bus.frame_idx, e.addr, e.hit, e.hit_px, e.fidx);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int px, py;
    reset_ah = 1'b1;
    bus.vs   = 1'b1;
    bus.drawX = '0;
    bus.drawY = '0;
    set_sprite(0, 0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge vga_clk);
    @(negedge vga_clk);
    phase = "reset";
    check_reset_outputs("reset_values");
    reset_ah = 1'b0;

    // Basic placement, frame 0, right edge and just past it
    phase = "basic";
    set_sprite(100, 50, 1'b0, 1'b0, 1'b0);
    vsync();
    pixel(100, 50);
    pixel(147, 50);
    pixel(148, 50);
    pixel(99, 50);
    pixel(120, 145);
    pixel(120, 146);

    // Mirror and sprite_hit_px lag
    phase = "mirror";
    set_sprite(100, 50, 1'b1, 1'b0, 1'b0);
    vsync();
    pixel(300, 300);
    pixel(100, 51);
    pixel(300, 300);
    pixel(147, 51);

    // Animation: 6 pulses per frame, 36 pulses wrap
    phase = "anim";
    set_sprite(100, 50, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) vsync();
    pixel(100, 50);
    for (int i = 0; i < 30; i++) begin
      vsync();
      pixel(101, 50);
    end

    // Restart wins over a due advance
    phase = "restart";
    for (int i = 0; i < 11; i++) vsync();
    bus.anim_restart = 1'b1;
    vsync();
    pixel(100, 50);
    bus.anim_restart = 1'b0;
    for (int i = 0; i < 5; i++) vsync();
    pixel(100, 50);
    vsync();
    pixel(100, 50);
    bus.anim_restart = 1'b1;
    for (int i = 0; i < 3; i++) vsync();
    pixel(110, 60);

    // Position change mid-frame is ignored until the next latch
    phase = "tear_free";
    set_sprite(100, 50, 1'b0, 1'b0, 1'b0);
    vsync();
    pixel(100, 60);
    bus.pos_x = 10'd200;
    pixel(100, 60);
    pixel(200, 60);
    vsync();
    pixel(100, 60);
    pixel(200, 60);

    // Clipping at the right edge
    phase = "clip";
    set_sprite(1000, 40, 1'b0, 1'b0, 1'b1);
    vsync();
    pixel(1023, 40);
    pixel(0, 40);
    pixel(1000, 135);

    // Reset mid-frame while outputs are active
    phase = "mid_reset";
    pixel(1010, 41);
    pixel(1011, 42);
    reset_ah = 1'b1;
    #1;
    check_reset_outputs("mid_frame_reset");
    model_reset();
    bus.vs = 1'b1;
    @(negedge vga_clk);
    reset_ah = 1'b0;
    set_sprite(100, 50, 1'b0, 1'b1, 1'b0);
    pixel(10, 10);
    pixel(100, 50);
    vsync();
    pixel(100, 50);

    // Random frames with mid-frame placement churn
    phase = "random";
    for (int f = 0; f < 40; f++) begin
      px = ($urandom_range(0, 3) == 0) ? int'($urandom_range(960, 1023)) : int'($urandom_range(0, 900));
      py = ($urandom_range(0, 3) == 0) ? int'($urandom_range(950, 1023)) : int'($urandom_range(0, 600));
      set_sprite(px, py, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0));
      vsync();
      for (int p = 0; p < 16; p++) begin
        if (p == 8) bus.pos_x = 10'($urandom_range(0, 1023));
        pixel(px + int'($urandom_range(0, SPR_W + 8)) - 4,
              py + int'($urandom_range(0, SPR_H + 8)) - 4);
      end
    end

    bus.drawX = 10'd1023;
    bus.drawY = 10'd1023;
    @(negedge vga_clk);
    @(negedge vga_clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
